// File: rtl/common_pkg.sv
// Shared UART definitions: line-control field positions, word-length codes and TX FSM states.
package common_pkg;

   localparam int unsigned LCR_WLS = 0;  // two-bit field [1:0]
   localparam int unsigned LCR_STB = 2;
   localparam int unsigned LCR_PEN = 3;
   localparam int unsigned LCR_EPS = 4;

   localparam logic [1:0] WLS_5 = 2'b00;
   localparam logic [1:0] WLS_6 = 2'b01;
   localparam logic [1:0] WLS_7 = 2'b10;
   localparam logic [1:0] WLS_8 = 2'b11;

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

   // Index of the last data bit sent for a given word-length code.
   function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
      return 3'd4 + {1'b0, wls};
   endfunction

   // Parity over the transmitted bits only.
   function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] wls,
                                        input logic even);
      logic [7:0] mask;
      logic       p;
      case (wls)
         WLS_5:   mask = 8'h1F;
         WLS_6:   mask = 8'h3F;
         WLS_7:   mask = 8'h7F;
         default: mask = 8'hFF;
      endcase
      p = ^(data & mask);
      return even ? p : ~p;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush; a push is accepted while full
// only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign count = wr_ptr_q - rd_ptr_q;
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   assign do_pop  = pop && !empty;
   assign do_push = push && !flush && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: TX FIFO feeding a serialiser with per-frame latched line settings
// and optional auto-CTS gating of the next frame start.
module uart_tx
   import common_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    tx_data_i,
   input  logic                          tx_start_i,
   input  logic [7:0]                    lcr_i,
   input  logic [DIV_W-1:0]              baud_div_i,
   input  logic                          fifo_flush_i,
   input  logic                          cts_en_i,
   input  logic                          cts_n_i,
   output logic                          tx_o,
   output logic                          tx_busy_o,
   output logic                          tx_done_o,
   output logic                          fifo_empty_o,
   output logic                          fifo_full_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic                          overflow_o
);

   tx_state_t        state_q, state_d;
   logic [DIV_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [2:0]       last_idx_q, last_idx_d;
   logic             pen_q, pen_d;
   logic             stop2_q, stop2_d;
   logic             stop_idx_q, stop_idx_d;
   logic             parity_q, parity_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;

   logic [7:0]       fifo_dout;
   logic             pop_req;
   logic             boundary;
   logic             unused_lcr;

   assign unused_lcr = ^lcr_i[7:5];

   assign pop_req  = (state_q == TX_IDLE) && !fifo_empty_o && (!cts_en_i || !cts_n_i);
   assign boundary = (bit_cnt_q == '0);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tx_start_i),
      .pop   (pop_req),
      .flush (fifo_flush_i),
      .din   (tx_data_i),
      .dout  (fifo_dout),
      .full  (fifo_full_o),
      .empty (fifo_empty_o),
      .count (fifo_count_o)
   );

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      div_d      = div_q;
      shreg_d    = shreg_q;
      bit_idx_d  = bit_idx_q;
      last_idx_d = last_idx_q;
      pen_d      = pen_q;
      stop2_d    = stop2_q;
      stop_idx_d = stop_idx_q;
      parity_d   = parity_q;
      tx_d       = tx_q;
      done_d     = 1'b0;
      // A full FIFO still accepts a write when the same cycle pops.
      ovf_d      = tx_start_i && !fifo_flush_i && fifo_full_o && !pop_req;

      if (state_q != TX_IDLE) begin
         bit_cnt_d = boundary ? div_q : bit_cnt_q - DIV_W'(1);
      end

      case (state_q)
         TX_IDLE: begin
            tx_d = 1'b1;
            if (pop_req) begin
               state_d    = TX_START;
               tx_d       = 1'b0;
               bit_cnt_d  = baud_div_i;
               div_d      = baud_div_i;
               shreg_d    = fifo_dout;
               bit_idx_d  = '0;
               last_idx_d = last_bit_idx(lcr_i[LCR_WLS +: 2]);
               pen_d      = lcr_i[LCR_PEN];
               stop2_d    = lcr_i[LCR_STB];
               stop_idx_d = 1'b0;
               parity_d   = calc_parity(fifo_dout, lcr_i[LCR_WLS +: 2], lcr_i[LCR_EPS]);
            end
         end
         TX_START: begin
            if (boundary) begin
               state_d   = TX_DATA;
               tx_d      = shreg_q[0];
               shreg_d   = shreg_q >> 1;
               bit_idx_d = '0;
            end
         end
         TX_DATA: begin
            if (boundary) begin
               if (bit_idx_q == last_idx_q) begin
                  state_d = pen_q ? TX_PARITY : TX_STOP;
                  tx_d    = pen_q ? parity_q : 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shreg_q[0];
                  shreg_d   = shreg_q >> 1;
               end
            end
         end
         TX_PARITY: begin
            if (boundary) begin
               state_d = TX_STOP;
               tx_d    = 1'b1;
            end
         end
         TX_STOP: begin
            if (boundary) begin
               if (stop2_q && !stop_idx_q) begin
                  stop_idx_d = 1'b1;
               end else begin
                  state_d = TX_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      busy_d = (state_d != TX_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= TX_IDLE;
         bit_cnt_q  <= '0;
         div_q      <= '0;
         shreg_q    <= '0;
         bit_idx_q  <= '0;
         last_idx_q <= '0;
         pen_q      <= 1'b0;
         stop2_q    <= 1'b0;
         stop_idx_q <= 1'b0;
         parity_q   <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         div_q      <= div_d;
         shreg_q    <= shreg_d;
         bit_idx_q  <= bit_idx_d;
         last_idx_q <= last_idx_d;
         pen_q      <= pen_d;
         stop2_q    <= stop2_d;
         stop_idx_q <= stop_idx_d;
         parity_q   <= parity_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

   assign tx_o       = tx_q;
   assign tx_busy_o  = busy_q;
   assign tx_done_o  = done_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: stimulus queues expected frames, a line monitor decodes tx_o per clock
// and compares each frame, its busy window and the done pulse against the queue.
module tb_uart_tx;

   localparam int unsigned FIFO_DEPTH = 16;
   localparam int unsigned DIV_W      = 16;

   typedef struct {
      logic [11:0] bits;  // line level per bit period, index 0 = start bit
      int          nb;
      int          div;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [7:0]       tx_data_i = '0;
   logic             tx_start_i = 1'b0;
   logic [7:0]       lcr_i = 8'h03;
   logic [DIV_W-1:0] baud_div_i = '0;
   logic             fifo_flush_i = 1'b0;
   logic             cts_en_i = 1'b0;
   logic             cts_n_i = 1'b0;
   logic             tx_o, tx_busy_o, tx_done_o, fifo_empty_o, fifo_full_o, overflow_o;
   logic [$clog2(FIFO_DEPTH):0] fifo_count_o;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   ovf_cnt = 0;
   bit   mon_en = 1'b1;

   always #5 clk = ~clk;

   uart_tx #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .DIV_W      (DIV_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tx_data_i    (tx_data_i),
      .tx_start_i   (tx_start_i),
      .lcr_i        (lcr_i),
      .baud_div_i   (baud_div_i),
      .fifo_flush_i (fifo_flush_i),
      .cts_en_i     (cts_en_i),
      .cts_n_i      (cts_n_i),
      .tx_o         (tx_o),
      .tx_busy_o    (tx_busy_o),
      .tx_done_o    (tx_done_o),
      .fifo_empty_o (fifo_empty_o),
      .fifo_full_o  (fifo_full_o),
      .fifo_count_o (fifo_count_o),
      .overflow_o   (overflow_o)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] b, input logic [7:0] lcr, input int div);
      exp_t e;
      int   k;
      logic p;
      e.bits = '0;
      k = 1;
      p = 1'b0;
      for (int i = 0; i < 5 + int'(lcr[1:0]); i++) begin
         e.bits[k] = b[i];
         p = p ^ b[i];
         k++;
      end
      if (lcr[3]) begin
         e.bits[k] = lcr[4] ? p : ~p;
         k++;
      end
      e.bits[k] = 1'b1;
      k++;
      if (lcr[2]) begin
         e.bits[k] = 1'b1;
         k++;
      end
      e.nb  = k;
      e.div = div;
      return e;
   endfunction

   always @(negedge clk) if (rst_n && overflow_o) ovf_cnt++;

   // Line monitor
   initial begin
      exp_t         e;
      logic [127:0] act, expv;
      int           per, len;
      bit           busy_ok, done_early;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n && tx_o === 1'b0) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_frame: got start bit, expected idle line");
               for (int w = 0; w < 200 && tx_o === 1'b0; w++) @(negedge clk);
            end else begin
               e = exp_q.pop_front();
               per = e.div + 1;
               len = e.nb * per;
               act = '0;
               expv = '0;
               busy_ok = 1'b1;
               done_early = 1'b0;
               for (int i = 0; i < len; i++) begin
                  if (i > 0) @(negedge clk);
                  act[i] = tx_o;
                  if (tx_busy_o !== 1'b1) busy_ok = 1'b0;
                  if (tx_done_o !== 1'b0) done_early = 1'b1;
               end
               for (int i = 0; i < e.nb; i++)
                  for (int j = 0; j < per; j++) expv[i*per+j] = e.bits[i];
               n_cmp++;
               if (act !== expv) begin
                  n_fail++;
                  $display("FAIL frame_wave: got %h expected %h", act, expv);
               end
               check("frame_busy", int'(busy_ok), 1);
               check("frame_done_early", int'(done_early), 0);
               @(negedge clk);
               check("done_pulse_done_busy_tx", int'({tx_done_o, tx_busy_o, tx_o}), 5);
            end
         end
      end
   end

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      while (k < budget && !(exp_q.size() == 0 && !tx_busy_o && fifo_empty_o)) begin
         @(negedge clk);
         k++;
      end
      check(name, int'(k < budget), 1);
      repeat (4) @(negedge clk);
   endtask

   task automatic enq(input logic [7:0] b, input exp_t e, input bit expect_frame);
      @(posedge clk);
      #1;
      tx_data_i  = b;
      tx_start_i = 1'b1;
      if (expect_frame) exp_q.push_back(e);
      @(posedge clk);
      #1;
      tx_start_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   ovf0, k;

      // Reset values
      #12;
      check("rst_tx", int'(tx_o), 1);
      check("rst_busy", int'(tx_busy_o), 0);
      check("rst_done", int'(tx_done_o), 0);
      check("rst_empty", int'(fifo_empty_o), 1);
      check("rst_full", int'(fifo_full_o), 0);
      check("rst_count", int'(fifo_count_o), 0);
      check("rst_ovf", int'(overflow_o), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 8N1, divisor 3, byte A5
      baud_div_i = 16'd3;
      lcr_i = 8'h03;
      e.bits = {2'b00, 1'b1, 8'hA5, 1'b0};
      e.nb = 10;
      e.div = 3;
      enq(8'hA5, e, 1'b1);
      wait_idle("idle_8n1", 200);

      // 6 data bits, even parity, 2 stop, byte 07
      lcr_i = 8'h1D;
      e.bits = {2'b00, 2'b11, 1'b1, 6'b000111, 1'b0};
      e.nb = 10;
      e.div = 3;
      enq(8'h07, e, 1'b1);
      wait_idle("idle_6e2", 200);

      // Fill past capacity while CTS blocks, divisor 0
      lcr_i = 8'h03;
      baud_div_i = '0;
      cts_en_i = 1'b1;
      cts_n_i = 1'b1;
      ovf0 = ovf_cnt;
      @(posedge clk);
      #1;
      for (int i = 0; i < 17; i++) begin
         tx_data_i = 8'(i * 13 + 1);
         tx_start_i = 1'b1;
         if (i < 16) exp_q.push_back(model(tx_data_i, lcr_i, 0));
         @(posedge clk);
         #1;
      end
      tx_start_i = 1'b0;
      repeat (3) @(negedge clk);
      check("full_flag", int'(fifo_full_o), 1);
      check("full_count", int'(fifo_count_o), 16);
      check("full_ovf_pulses", ovf_cnt - ovf0, 1);
      check("blocked_tx_high", int'(tx_o), 1);
      check("blocked_not_busy", int'(tx_busy_o), 0);

      // Release CTS with a write in the same cycle as the pop
      @(posedge clk);
      #1;
      cts_n_i = 1'b0;
      tx_data_i = 8'hEE;
      tx_start_i = 1'b1;
      exp_q.push_back(model(8'hEE, 8'h03, 0));
      @(posedge clk);
      #1;
      tx_start_i = 1'b0;
      @(negedge clk);
      check("pop_push_count", int'(fifo_count_o), 16);
      check("pop_push_no_ovf", int'(overflow_o), 0);
      check("pop_push_busy", int'(tx_busy_o), 1);
      wait_idle("idle_burst", 1000);
      check("burst_ovf_total", ovf_cnt - ovf0, 1);

      // Flush during DATA with 5 bytes queued
      baud_div_i = 16'd1;
      cts_n_i = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         tx_data_i = 8'h30 + 8'(i);
         tx_start_i = 1'b1;
         if (i == 0) exp_q.push_back(model(tx_data_i, lcr_i, 1));
         @(posedge clk);
         #1;
      end
      tx_start_i = 1'b0;
      @(negedge clk);
      check("flush_pre_count", int'(fifo_count_o), 5);
      cts_n_i = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      ovf0 = ovf_cnt;
      fifo_flush_i = 1'b1;
      tx_data_i = 8'h99;
      tx_start_i = 1'b1;
      @(posedge clk);
      #1;
      fifo_flush_i = 1'b0;
      tx_start_i = 1'b0;
      @(negedge clk);
      check("flush_empty", int'(fifo_empty_o), 1);
      check("flush_count", int'(fifo_count_o), 0);
      check("flush_no_ovf", int'(overflow_o), 0);
      check("flush_frame_alive", int'(tx_busy_o), 1);
      wait_idle("idle_flush", 200);
      repeat (40) @(negedge clk);
      check("flush_no_more_frames", int'({tx_busy_o, fifo_empty_o}), 1);
      check("flush_ovf_none", ovf_cnt - ovf0, 0);

      // Asynchronous reset in the middle of DATA
      mon_en = 1'b0;
      cts_en_i = 1'b0;
      baud_div_i = 16'd3;
      for (int i = 0; i < 3; i++) enq(8'h00, e, 1'b0);
      k = 0;
      while (k < 50 && tx_o !== 1'b0) begin
         @(negedge clk);
         k++;
      end
      check("rst_test_frame_started", int'(k < 50), 1);
      repeat (10) @(posedge clk);
      #1;
      check("pre_reset_tx_low", int'(tx_o), 0);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_tx", int'(tx_o), 1);
      check("async_rst_busy", int'(tx_busy_o), 0);
      check("async_rst_empty", int'(fifo_empty_o), 1);
      check("async_rst_count", int'(fifo_count_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("post_rst_tx", int'(tx_o), 1);
      check("post_rst_busy", int'(tx_busy_o), 0);
      check("post_rst_empty", int'(fifo_empty_o), 1);
      mon_en = 1'b1;
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmit stage, directly downstream of the AXI4-Lite UART register block.
- Consumes the transmit data register, line control, operation control start pulse, FIFO control and handshake control outputs.
- Buffers bytes in a small TX FIFO and serialises them onto tx_o as start / 5-8 data bits / optional parity / 1-2 stop bits, at a programmable baud divisor.
- Status outputs feed the line status and interrupt identification inputs of the register block.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, minimum 2.
- DIV_W, 16, width of the baud divisor.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tx_data_i  in  8  byte to enqueue (TDR[7:0])
- tx_start_i  in  1  one-cycle enqueue strobe (OCR[1] pulse)
- lcr_i  in  8  line control: [1:0] data bits (00=5, 01=6, 10=7, 11=8); [2] stop (0=1, 1=2); [3] parity enable; [4] even parity
- baud_div_i  in  DIV_W  bit period = baud_div_i+1 clocks
- fifo_flush_i  in  1  FCR[1]; level-sensitive FIFO clear
- cts_en_i  in  1  HCR[0]; enables auto-CTS gating
- cts_n_i  in  1  clear-to-send, active-low, already synchronised
- tx_o  out  1  serial line, idle high
- tx_busy_o  out  1  frame in progress
- tx_done_o  out  1  one-cycle pulse at end of last stop bit
- fifo_empty_o  out  1  FIFO empty
- fifo_full_o  out  1  FIFO full
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  occupancy
- overflow_o  out  1  one-cycle pulse when an enqueue is dropped

Behaviour:
- Reset values: tx_o=1, tx_busy_o=0, tx_done_o=0, fifo_empty_o=1, fifo_full_o=0, fifo_count_o=0, overflow_o=0. FIFO pointers are cleared and the FSM returns to IDLE.
- Reset asserted mid-frame aborts the frame immediately; tx_o returns high asynchronously.
- Enqueue rules:
  - tx_start_i=1 writes tx_data_i when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the write is dropped and overflow_o pulses for one cycle.
  - The FIFO holds its contents; there is no overwrite.
- Flush:
  - fifo_flush_i=1 clears pointers and count on that clock edge.
  - A simultaneous tx_start_i is dropped; overflow_o stays 0.
  - The frame in progress is not aborted.
- Pop condition: state IDLE, FIFO not empty, and (cts_en_i=0 or cts_n_i=0).
  - On the pop edge, the byte, lcr_i and baud_div_i are latched into frame registers.
  - The next state is START, so tx_o falls one clock after the pop cycle.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - A bit counter of DIV_W bits reloads at every bit boundary and counts baud_div_i+1 clocks per bit.
  - START: tx_o=0 for one bit period.
  - DATA: LSB first, N = 5 + lcr[1:0] bits.
  - PARITY: entered only if lcr[3]=1. Bit = XOR(data[N-1:0]) when even, inverted when odd; only the N transmitted bits count.
  - STOP: tx_o=1 for 1 or 2 bit periods. tx_done_o pulses on the final clock of the last stop bit, and the FSM then returns to IDLE.
- Inter-frame gap: minimum one clock (the IDLE pop cycle) plus the stop bits.
- tx_busy_o=1 in every state except IDLE.
- CTS deassertion mid-frame does not stop the frame; it only blocks the next pop.
- Changes to lcr_i or baud_div_i mid-frame have no effect until the next frame.
- baud_div_i=0 is legal and gives a 1-clock bit period.
- All outputs are registered except fifo_empty_o, fifo_full_o and fifo_count_o, which are decoded from registered pointers.

Decomposition:
- common_pkg:
  - LCR field bit-index constants (LCR_WLS, LCR_STB, LCR_PEN, LCR_EPS).
  - Enum tx_state_t {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP}.
  - Word-length encoding constants.
- Sub-module sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports push, pop, flush, din, dout (first-word-fall-through), full, empty, count.
  - Reusable later by the RX path.

Test Plan:
- baud_div=3, lcr=8'h03 (8N1), enqueue 8'hA5 -> tx_o low at pop+1 for 4 clocks, then 1,0,1,0,0,1,0,1 at 4 clocks each, then high for 4 clocks; tx_done_o pulses at clock 40 after the fall; tx_busy_o is high throughout.
- lcr=8'h1D (6 data bits, even parity, 2 stop), byte 8'h07 -> data bits 1,1,1,0,0,0, parity 1, two stop bits; total frame 10 bit periods.
- Push 17 bytes back-to-back with FIFO_DEPTH=16 while CTS is blocked (cts_en=1, cts_n=1) -> fifo_full_o=1, fifo_count_o=16, overflow_o pulses once, tx_o stays high. Releasing cts_n then transmits 16 frames in order.
- FIFO full, then tx_start_i coincides with a pop -> write accepted, count stays 16, no overflow.
- fifo_flush_i during the DATA state with 5 bytes queued -> current frame completes intact, fifo_empty_o=1, no further frames.
- Reset asserted mid-DATA -> tx_o=1 immediately without waiting for a clock edge; after release, FIFO is empty and FSM is IDLE.
